debounce4: RTL and testbench

DEBOUNCE4 -- requirements
Module: debounce4

---
 rtl/debounce4.sv | 91 +++++++++
 tb/tb_debounce4.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/debounce4.sv
// Four independent debounce channels: 2-flop synchronizer, stability counter, registered level.
// Optional rising-edge pulse outputs e0..e3 enabled by macro DEBOUNCE4_EDGE_EN.
module debounce4 #(
  parameter int unsigned N_CYCLES = 12000,
  parameter int unsigned CNT_W    = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  output logic z0,
  output logic z1,
  output logic z2,
  output logic z3,
  output logic e0,
  output logic e1,
  output logic e2,
  output logic e3
);

  localparam int unsigned N_CH = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_CYCLES - 1);

  logic [N_CH-1:0] w_x;
  logic [N_CH-1:0] w_z;
  logic [N_CH-1:0] w_e;

  assign w_x = {x3, x2, x1, x0};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             r_s1;
    logic             r_s2;
    logic             r_z;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_z_nxt;

    // Counter clears whenever the synchronized input agrees with the output,
    // so any single agreeing cycle restarts the stability window.
    always_comb begin
      w_cnt_nxt = '0;
      w_z_nxt   = r_z;
      if (r_s2 != r_z) begin
        if (r_cnt == CNT_MAX) begin
          w_z_nxt = r_s2;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1  <= 1'b0;
        r_s2  <= 1'b0;
        r_cnt <= '0;
        r_z   <= 1'b0;
      end else begin
        r_s1  <= w_x[i];
        r_s2  <= r_s1;
        r_cnt <= w_cnt_nxt;
        r_z   <= w_z_nxt;
      end
    end

    assign w_z[i] = r_z;

`ifdef DEBOUNCE4_EDGE_EN
    logic r_e;

    // Pulse is set on the same edge that raises z, so it is high exactly while z first reads 1.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_e <= 1'b0;
      end else begin
        r_e <= w_z_nxt & ~r_z;
      end
    end

    assign w_e[i] = r_e;
`else
    assign w_e[i] = 1'b0;
`endif
  end

  assign {z3, z2, z1, z0} = w_z;
  assign {e3, e2, e1, e0} = w_e;

endmodule

// File: tb/tb_debounce4.sv
// Directed self-checking bench for debounce4 with N_CYCLES=4, CNT_W=3.
// Edge-pulse expectations follow DEBOUNCE4_EDGE_EN; z expectations are identical in both builds.
module tb_debounce4;

  localparam int unsigned N_CYCLES = 4;
  localparam int unsigned CNT_W    = 3;
`ifdef DEBOUNCE4_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic x0, x1, x2, x3;
  logic z0, z1, z2, z3;
  logic e0, e1, e2, e3;

  int n_vec = 0;
  int n_err = 0;

  debounce4 #(.N_CYCLES(N_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .z0(z0), .z1(z1), .z2(z2), .z3(z3),
    .e0(e0), .e1(e1), .e2(e2), .e3(e3)
  );

  always #5 clk = ~clk;

  task automatic set_x(input logic [3:0] v);
    {x3, x2, x1, x0} = v;
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp_z, input logic [3:0] exp_e);
    logic [3:0] obs_z;
    logic [3:0] obs_e;
    logic       exp_and;
    obs_z   = {z3, z2, z1, z0};
    obs_e   = {e3, e2, e1, e0};
    exp_and = &exp_z;
    n_vec++;
    assert (obs_z === exp_z) else begin
      n_err++;
      $error("FAIL %s z observed=%b expected=%b", tag, obs_z, exp_z);
    end
    n_vec++;
    assert (obs_e === exp_e) else begin
      n_err++;
      $error("FAIL %s e observed=%b expected=%b", tag, obs_e, exp_e);
    end
    n_vec++;
    assert ((z0 & z1 & z2 & z3) === exp_and) else begin
      n_err++;
      $error("FAIL %s and observed=%b expected=%b", tag, z0 & z1 & z2 & z3, exp_and);
    end
  endtask

  initial begin
    rst = 1'b0;
    set_x(4'b1111);

    // Asynchronous reset, before any clock edge
    #2 rst = 1'b1;
    #1 chk("rst_async", 4'b0000, 4'b0000);
    set_x(4'b0001);
    clk_n(2);
    chk("rst_hold", 4'b0000, 4'b0000);
    rst = 1'b0;
    clk_n(5);
    chk("rel_5edges", 4'b0000, 4'b0000);
    clk_n(1);
    chk("rel_6edges", 4'b0001, {3'b000, EDGE});
    clk_n(1);
    chk("rel_pulse_end", 4'b0001, 4'b0000);

    // Glitches on x1: two 3-sample bursts split by one low sample
    set_x(4'b0011); clk_n(1); chk("glitch_a1", 4'b0001, 4'b0000);
    clk_n(1);               chk("glitch_a2", 4'b0001, 4'b0000);
    clk_n(1);               chk("glitch_a3", 4'b0001, 4'b0000);
    set_x(4'b0001); clk_n(1); chk("glitch_gap", 4'b0001, 4'b0000);
    set_x(4'b0011);
    for (int k = 0; k < 3; k++) begin
      clk_n(1); chk("glitch_b", 4'b0001, 4'b0000);
    end
    set_x(4'b0001);
    for (int k = 0; k < 8; k++) begin
      clk_n(1); chk("glitch_tail", 4'b0001, 4'b0000);
    end

    // Bounce on x2: samples 1,0,1,0,1 then held high
    set_x(4'b0101); clk_n(1);
    set_x(4'b0001); clk_n(1);
    set_x(4'b0101); clk_n(1);
    set_x(4'b0001); clk_n(1);
    set_x(4'b0101); clk_n(1);
    chk("bounce_final_sample", 4'b0001, 4'b0000);
    clk_n(4);
    chk("bounce_5edges", 4'b0001, 4'b0000);
    clk_n(1);
    chk("bounce_6edges", 4'b0101, {1'b0, EDGE, 2'b00});
    clk_n(1);
    chk("bounce_pulse_end", 4'b0101, 4'b0000);

    // Symmetric fall of z0 and z2
    set_x(4'b0000);
    clk_n(5);
    chk("fall_5edges", 4'b0101, 4'b0000);
    clk_n(1);
    chk("fall_6edges", 4'b0000, 4'b0000);
    clk_n(3);
    chk("fall_settled", 4'b0000, 4'b0000);

    // All four rise together
    set_x(4'b1111);
    clk_n(5);
    chk("all_5edges", 4'b0000, 4'b0000);
    clk_n(1);
    chk("all_6edges", 4'b1111, {4{EDGE}});
    clk_n(1);
    chk("all_pulse_end", 4'b1111, 4'b0000);

    // x3 drops; only z3 follows
    set_x(4'b0111);
    clk_n(5);
    chk("x3_drop_5edges", 4'b1111, 4'b0000);
    clk_n(1);
    chk("x3_drop_6edges", 4'b0111, 4'b0000);
    clk_n(3);
    chk("x3_drop_settled", 4'b0111, 4'b0000);

    // Asynchronous reset mid-cycle with outputs high
    #2 rst = 1'b1;
    #1 chk("rst_async_mid", 4'b0000, 4'b0000);
    set_x(4'b0000);
    clk_n(1);
    rst = 1'b0;
    clk_n(3);
    chk("idle_after_rst", 4'b0000, 4'b0000);

    // Reset during a count discards progress
    set_x(4'b0001);
    clk_n(3);
    chk("midcount_pre", 4'b0000, 4'b0000);
    rst = 1'b1;
    clk_n(1);
    chk("midcount_in_rst", 4'b0000, 4'b0000);
    rst = 1'b0;
    clk_n(5);
    chk("midcount_5edges", 4'b0000, 4'b0000);
    clk_n(1);
    chk("midcount_6edges", 4'b0001, {3'b000, EDGE});
    clk_n(1);
    chk("midcount_pulse_end", 4'b0001, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
